// File: rtl/arbitro_rr_pkg.sv
// Shared types and helpers for the arbitro_rr round-robin arbiter.
// Optional grant timeout is enabled by defining ARBITRO_RR_TIMEOUT_EN.
package arbitro_pkg;

  localparam int N_DEFAULT = 4;
  localparam int ONEHOT_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Callers slice the result down to their own N.
  function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int n);
    logic [ONEHOT_W-1:0] result;
    result = '0;
    if (idx >= 0 && idx < n && idx < ONEHOT_W) begin
      result[idx] = 1'b1;
    end else begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// The preempt line only toggles when ARBITRO_RR_TIMEOUT_EN is defined.
interface arbitro_rr_if #(
  parameter int N = arbitro_pkg::N_DEFAULT
);
  localparam int NUM_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [NUM_W-1:0] grant_num;
  logic             available;
  logic             preempt;

  modport master (
    output req,
    input  grant, grant_num, available, preempt
  );

  modport slave (
    input  req,
    output grant, grant_num, available, preempt
  );
endinterface

// File: rtl/arbitro_rr_pick.sv
// Combinational rotate-priority find-first: first set bit of req & ~exclude,
// searching upward from ptr and wrapping at N-1.
module arbitro_rr_pick #(
  parameter int N     = arbitro_pkg::N_DEFAULT,
  parameter int NUM_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [NUM_W-1:0] i_ptr,
  input  logic [N-1:0]     i_excl,
  output logic             o_found,
  output logic [NUM_W-1:0] o_idx
);

  logic [N-1:0]   w_cand;
  logic [NUM_W:0] w_pos;

  // Walk from the farthest offset back to ptr so the nearest candidate wins last.
  always_comb begin
    w_cand  = i_req & ~i_excl;
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos   = {1'b0, i_ptr} + (NUM_W+1)'(k);
      w_pos   = (w_pos >= (NUM_W+1)'(N)) ? (w_pos - (NUM_W+1)'(N)) : w_pos;
      o_found = o_found | w_cand[w_pos[NUM_W-1:0]];
      o_idx   = w_cand[w_pos[NUM_W-1:0]] ? w_pos[NUM_W-1:0] : o_idx;
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Registered round-robin arbiter: grant is held until the owner releases it.
// Define ARBITRO_RR_TIMEOUT_EN to revoke grants held MAX_HOLD cycles under contention.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  arbitro_rr_if.slave   bus
);

  localparam int NUM_W = $clog2(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("arbitro_rr: N must be >= 2 and MAX_HOLD >= 1");
  end

  state_t           r_state;
  logic [N-1:0]     r_grant;
  logic [NUM_W-1:0] r_grant_num;
  logic             r_available;
  logic [NUM_W-1:0] r_ptr;

  logic             w_found;
  logic [NUM_W-1:0] w_idx;
  logic [N-1:0]     w_onehot;
  logic             w_owner_req;
  logic             w_timeout;
  logic             w_take;
  logic             w_release;

  // The current owner is always excluded; in IDLE r_grant is zero anyway.
  arbitro_rr_pick #(.N(N), .NUM_W(NUM_W)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .i_excl  (r_grant),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_onehot    = N'(onehot(int'(w_idx), N));
  assign w_owner_req = bus.req[r_grant_num];

`ifdef ARBITRO_RR_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_preempt;
  assign w_timeout   = w_owner_req && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign bus.preempt = r_preempt;
`else
  assign w_timeout   = 1'b0;
  assign bus.preempt = 1'b0;
`endif

  // Decide whether this edge hands out a new grant or returns to idle.
  always_comb begin
    w_take    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        w_take = w_found;
      end
      BUSY: begin
        w_take    = w_found && (!w_owner_req || w_timeout);
        w_release = !w_owner_req && !w_found;
      end
      default: begin
        w_release = 1'b1;
      end
    endcase
  end

  // FSM, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_num <= '0;
      r_available <= 1'b1;
      r_ptr       <= '0;
`ifdef ARBITRO_RR_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_preempt   <= 1'b0;
`endif
    end else if (w_take) begin
      r_state     <= BUSY;
      r_grant     <= w_onehot;
      r_grant_num <= w_idx;
      r_available <= 1'b0;
      r_ptr       <= (w_idx == NUM_W'(N - 1)) ? '0 : (w_idx + NUM_W'(1));
`ifdef ARBITRO_RR_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_preempt   <= w_timeout;
`endif
    end else if (w_release) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_num <= '0;
      r_available <= 1'b1;
`ifdef ARBITRO_RR_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_preempt   <= 1'b0;
`endif
    end else begin
`ifdef ARBITRO_RR_TIMEOUT_EN
      // Saturate at MAX_HOLD-1 while nobody else is waiting.
      if (r_state == BUSY && r_hold_cnt != HOLD_W'(MAX_HOLD - 1)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
      r_preempt <= 1'b0;
`endif
    end
  end

  assign bus.grant     = r_grant;
  assign bus.grant_num = r_grant_num;
  assign bus.available = r_available;

endmodule
